// File: rtl/encoder128to7_pipe_if.sv
// Stream bundle for the 128-to-7 encoder: one-hot words in, index/found/multi out.
interface encoder128to7_pipe_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] onehot;
  logic         out_valid;
  logic         out_ready;
  logic [6:0]   index;
  logic         found;
  logic         multi;

  modport master (
    output in_valid, onehot, out_ready,
    input  in_ready, out_valid, index, found, multi
  );

  modport slave (
    input  in_valid, onehot, out_ready,
    output in_ready, out_valid, index, found, multi
  );
endinterface

// File: rtl/encoder128to7_pipe.sv
// Two-stage elastic 128-to-7 priority encoder: per-group encode, then group select.
module encoder128to7_pipe #(
  parameter int GROUP_W = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  encoder128to7_pipe_if.slave  bus
);
  localparam int NGROUP = 128 / GROUP_W;
  localparam int LO_W   = $clog2(GROUP_W);
  localparam int SEL_W  = $clog2(NGROUP);

  function automatic logic [LO_W-1:0] enc_lo(input logic [GROUP_W-1:0] v);
    logic [LO_W-1:0] r;
    r = '0;
    for (int i = GROUP_W - 1; i >= 0; i--)
      if (v[i]) r = LO_W'(i);
    return r;
  endfunction

  function automatic logic is_multi(input logic [GROUP_W-1:0] v);
    return (v & (v - GROUP_W'(1))) != '0;
  endfunction

  logic [NGROUP-1:0] any_p0, mul_p0;
  logic [LO_W-1:0]   lo_p0 [NGROUP];

  always_comb begin
    any_p0 = '0;
    mul_p0 = '0;
    for (int g = 0; g < NGROUP; g++) begin
      any_p0[g] = |bus.onehot[g*GROUP_W +: GROUP_W];
      mul_p0[g] = is_multi(bus.onehot[g*GROUP_W +: GROUP_W]);
      lo_p0[g]  = enc_lo(bus.onehot[g*GROUP_W +: GROUP_W]);
    end
  end

  // ---- stage 1: group results ----
  logic              vld_p1;
  logic [NGROUP-1:0] any_p1, mul_p1;
  logic [LO_W-1:0]   lo_p1 [NGROUP];
  logic              vld_p2;
  logic              adv_out;

  assign adv_out      = ~vld_p2 | bus.out_ready;
  assign bus.in_ready = ~vld_p1 | adv_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      any_p1 <= '0;
      mul_p1 <= '0;
      for (int g = 0; g < NGROUP; g++) lo_p1[g] <= '0;
    end else if (bus.in_ready) begin
      vld_p1 <= bus.in_valid;
      any_p1 <= any_p0;
      mul_p1 <= mul_p0;
      for (int g = 0; g < NGROUP; g++) lo_p1[g] <= lo_p0[g];
    end
  end

  logic [SEL_W-1:0] gsel;
  logic [6:0]       index_nx;
  logic             found_nx, multi_nx;

  // Lowest populated group wins; an empty word falls through to group 0 with lo=0.
  always_comb begin
    gsel = '0;
    for (int g = NGROUP - 1; g >= 0; g--)
      if (any_p1[g]) gsel = SEL_W'(g);
    index_nx = {gsel, lo_p1[gsel]};
    found_nx = |any_p1;
    multi_nx = ((any_p1 & (any_p1 - NGROUP'(1))) != '0) | mul_p1[gsel];
  end

  // ---- stage 2: final result ----
  logic [6:0] index_p2;
  logic       found_p2, multi_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2   <= 1'b0;
      index_p2 <= '0;
      found_p2 <= 1'b0;
      multi_p2 <= 1'b0;
    end else if (adv_out) begin
      vld_p2   <= vld_p1;
      index_p2 <= index_nx;
      found_p2 <= found_nx;
      multi_p2 <= multi_nx;
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.index     = index_p2;
  assign bus.found     = found_p2;
  assign bus.multi     = multi_p2;
endmodule
